// File: rtl/subtract_mask.sv
// subtract_mask: foreground/background subtraction stage.
//
// Pops one grayscale pixel from the current-frame FIFO and one from the
// background FIFO in the same cycle. It takes the absolute difference of the
// two pixels and compares it with THRESHOLD. It then pushes one mask byte into
// the mask FIFO: 0xFF for motion, 0x00 for static. The frame_done output
// pulses for one cycle after the last pixel of each frame is written.
//
// Parameters:
//   THRESHOLD     mask is 0xFF when |fg - bg| > THRESHOLD (strict), 0..255
//   FRAME_PIXELS  pixels per frame, >= 1
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-low reset
//   fg_read_enable  pop current-frame FIFO
//   fg_din          current-frame pixel (first-word-fall-through)
//   fg_fifo_empty   current-frame FIFO empty
//   bg_read_enable  pop background FIFO
//   bg_din          background pixel (first-word-fall-through)
//   bg_fifo_empty   background FIFO empty
//   write_enable    push mask FIFO
//   data_out        mask byte, 0xFF or 0x00
//   fifo_out_full   mask FIFO full
//   frame_done      one-cycle pulse after the final write of a frame

module subtract_mask #(
  parameter int unsigned THRESHOLD    = 50,
  parameter int unsigned FRAME_PIXELS = 1024
) (
  input  logic       clk,
  input  logic       reset,
  output logic       fg_read_enable,
  input  logic [7:0] fg_din,
  input  logic       fg_fifo_empty,
  output logic       bg_read_enable,
  input  logic [7:0] bg_din,
  input  logic       bg_fifo_empty,
  output logic       write_enable,
  output logic [7:0] data_out,
  input  logic       fifo_out_full,
  output logic       frame_done
);

  localparam int unsigned CountW = $clog2(FRAME_PIXELS + 1);
  localparam logic [CountW-1:0] LastCount = CountW'(FRAME_PIXELS - 1);
  localparam logic [7:0] Thresh = 8'(THRESHOLD);

  typedef enum logic [1:0] {
    StRead,
    StCompute,
    StWrite
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        fg_q, fg_d;
  logic [7:0]        bg_q, bg_d;
  logic [7:0]        mask_q, mask_d;
  logic [CountW-1:0] count_q, count_d;
  logic              frame_done_q, frame_done_d;

  logic              pop;
  logic              push;
  logic [7:0]        diff;

  // The subtraction always takes the larger operand minus the smaller one,
  // so the result fits in 8 bits.
  always_comb begin
    if (fg_q >= bg_q) begin
      diff = fg_q - bg_q;
    end else begin
      diff = bg_q - fg_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    mask_d       = mask_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      StRead: begin
        // Both FIFOs pop together or neither does.
        if (!fg_fifo_empty && !bg_fifo_empty) begin
          pop     = 1'b1;
          fg_d    = fg_din;
          bg_d    = bg_din;
          state_d = StCompute;
        end
      end
      StCompute: begin
        mask_d  = (diff > Thresh) ? 8'hFF : 8'h00;
        state_d = StWrite;
      end
      StWrite: begin
        if (!fifo_out_full) begin
          push    = 1'b1;
          state_d = StRead;
          if (count_q == LastCount) begin
            count_d      = '0;
            frame_done_d = 1'b1;
          end else begin
            count_d = count_q + CountW'(1);
          end
        end
      end
      default: begin
        state_d = StRead;
      end
    endcase
  end

  // Enables are held low while reset is asserted. Without this gating, the
  // READ state would pop the FIFOs during reset.
  assign fg_read_enable = pop & reset;
  assign bg_read_enable = pop & reset;
  assign write_enable   = push & reset;
  assign data_out       = mask_q;
  assign frame_done     = frame_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRead;
      fg_q         <= 8'h00;
      bg_q         <= 8'h00;
      mask_q       <= 8'h00;
      count_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
      mask_q       <= mask_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_subtract_mask.sv
// Directed testbench for subtract_mask with THRESHOLD=50 and FRAME_PIXELS=4.
module tb_subtract_mask;

  logic       clk;
  logic       reset;
  logic       fg_read_enable;
  logic [7:0] fg_din;
  logic       fg_fifo_empty;
  logic       bg_read_enable;
  logic [7:0] bg_din;
  logic       bg_fifo_empty;
  logic       write_enable;
  logic [7:0] data_out;
  logic       fifo_out_full;
  logic       frame_done;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  subtract_mask #(
    .THRESHOLD   (50),
    .FRAME_PIXELS(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fg_read_enable(fg_read_enable),
    .fg_din        (fg_din),
    .fg_fifo_empty (fg_fifo_empty),
    .bg_read_enable(bg_read_enable),
    .bg_din        (bg_din),
    .bg_fifo_empty (bg_fifo_empty),
    .write_enable  (write_enable),
    .data_out      (data_out),
    .fifo_out_full (fifo_out_full),
    .frame_done    (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a negedge with the DUT in READ. Pushes one pixel pair
  // through the pipeline, optionally holding the output FIFO full for `stall`
  // cycles in WRITE, and checks the full pop/compute/write/frame_done timing.
  task automatic do_pair(input logic [7:0] fg, input logic [7:0] bg,
                         input logic [7:0] exp_mask, input int stall);
    bit exp_done;
    fg_din        = fg;
    bg_din        = bg;
    fg_fifo_empty = 1'b0;
    bg_fifo_empty = 1'b0;
    fifo_out_full = 1'b0;
    #1;
    check("pop_fg", 32'(fg_read_enable), 32'd1);
    check("pop_bg", 32'(bg_read_enable), 32'd1);
    check("we_in_read", 32'(write_enable), 32'd0);
    @(negedge clk);
    // Inputs change after the pop; the latched pair must be unaffected.
    fg_fifo_empty = 1'b1;
    bg_fifo_empty = 1'b1;
    fg_din        = ~fg;
    bg_din        = ~bg;
    #1;
    check("compute_pop", 32'({fg_read_enable, bg_read_enable}), 32'd0);
    check("compute_we", 32'(write_enable), 32'd0);
    check("compute_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    if (stall > 0) begin
      fifo_out_full = 1'b1;
      fg_fifo_empty = 1'b0;
      bg_fifo_empty = 1'b0;
      for (int i = 0; i < stall; i++) begin
        #1;
        check("stall_we", 32'(write_enable), 32'd0);
        check("stall_pop", 32'({fg_read_enable, bg_read_enable}), 32'd0);
        @(negedge clk);
      end
      fifo_out_full = 1'b0;
      fg_fifo_empty = 1'b1;
      bg_fifo_empty = 1'b1;
    end
    #1;
    check("write_we", 32'(write_enable), 32'd1);
    check("write_data", 32'(data_out), 32'(exp_mask));
    check("write_fd", 32'(frame_done), 32'd0);
    wr_count++;
    exp_done = (wr_count % 4) == 0;
    @(negedge clk);
    #1;
    check("frame_done", 32'(frame_done), 32'(exp_done));
    check("after_we", 32'(write_enable), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    fg_din        = 8'h00;
    bg_din        = 8'h00;
    fg_fifo_empty = 1'b1;
    bg_fifo_empty = 1'b1;
    fifo_out_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pop", 32'({fg_read_enable, bg_read_enable}), 32'd0);
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Frame 1: basic, absolute difference, strict threshold, saturated equal.
    do_pair(8'd100, 8'd40, 8'hFF, 0);
    do_pair(8'd40, 8'd100, 8'hFF, 0);
    do_pair(8'd90, 8'd40, 8'h00, 0);
    do_pair(8'd255, 8'd255, 8'h00, 0);

    // Only one FIFO non-empty: no pops.
    fg_fifo_empty = 1'b1;
    bg_fifo_empty = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("empty_pop", 32'({fg_read_enable, bg_read_enable}), 32'd0);
      @(negedge clk);
    end

    // Frame 2: release fg, then a five-cycle stall with output backpressure.
    do_pair(8'd10, 8'd200, 8'hFF, 0);
    do_pair(8'd200, 8'd0, 8'hFF, 5);
    do_pair(8'd0, 8'd0, 8'h00, 0);
    do_pair(8'd51, 8'd0, 8'hFF, 0);
    // Ninth pair leaves the frame counter at 1.
    do_pair(8'd200, 8'd10, 8'hFF, 0);

    // Reset during COMPUTE after popping 255/0: the pair is never written.
    fg_din        = 8'd255;
    bg_din        = 8'd0;
    fg_fifo_empty = 1'b0;
    bg_fifo_empty = 1'b0;
    #1;
    check("rst_mid_pop", 32'({fg_read_enable, bg_read_enable}), 32'd3);
    @(negedge clk);
    fg_fifo_empty = 1'b1;
    bg_fifo_empty = 1'b1;
    reset         = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_we", 32'(write_enable), 32'd0);
    check("rst_mid_data", 32'(data_out), 32'd0);
    check("rst_mid_fd", 32'(frame_done), 32'd0);
    check("rst_mid_pop0", 32'({fg_read_enable, bg_read_enable}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("post_rst_we", 32'(write_enable), 32'd0);
      @(negedge clk);
    end

    // The counter restarts at 0, so frame_done follows the fourth write only.
    wr_count = 0;
    do_pair(8'd120, 8'd70, 8'h00, 0);
    do_pair(8'd121, 8'd70, 8'hFF, 0);
    do_pair(8'd0, 8'd255, 8'hFF, 0);
    do_pair(8'd7, 8'd9, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
